arm_dmem_ctrl: RTL and testbench

//  Data-memory stage downstream of the pipelined ARM core. Takes the core's memory request
//  (ALUResult, WriteData, byteEnable, MemWrite, load strobe) and runs it on a wait-stated

---
 rtl/arm_dmem_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_arm_dmem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_dmem_ctrl.sv
// Data-memory stage between the pipelined ARM core and a wait-stated valid/ready bus.
// Optional DMEM_WBUF_EN adds a one-entry posted write buffer in front of the bus FSM.
module arm_dmem_ctrl #(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  input  logic              core_we,
  input  logic              core_re,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              core_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_r;
  state_t              state_s;
  logic                req_s;
  logic                noop_s;
  logic                start_s;
  logic                abort_s;
  logic                tmo_hit_s;
  logic [15:0]         tmo_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [3:0]          be_r;
  logic                we_r;
  logic [31:0]         rdata_r;
  logic                err_r;
  logic                addr_unused_s;

`ifdef DMEM_WBUF_EN
  logic                wb_valid_r;
  logic [ADDR_W-1:0]   wb_addr_r;
  logic [31:0]         wb_wdata_r;
  logic [3:0]          wb_be_r;
  logic                buf_txn_r;
  logic                start_buf_s;
  logic                wb_push_s;
`endif

  assign req_s         = core_we | core_re;
  assign noop_s        = core_we & (core_be == 4'h0);
  assign tmo_hit_s     = (tmo_cnt_r == TMO_LAST);
  assign addr_unused_s = ^core_addr[1:0];

  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign mem_be     = be_r;
  assign mem_we     = we_r;
  assign core_rdata = rdata_r;
  assign core_err   = err_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a handshake in the last allowed cycle wins over the timeout
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    abort_s = 1'b0;
`ifdef DMEM_WBUF_EN
    start_buf_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
`ifdef DMEM_WBUF_EN
        if (wb_valid_r) begin
          state_s     = REQ;
          start_s     = 1'b1;
          start_buf_s = 1'b1;
        end else if (core_re && !core_we) begin
          state_s = REQ;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
`else
        if (req_s && !noop_s) begin
          state_s = REQ;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
`endif
      end
      REQ: begin
        if (mem_ready) begin
          state_s = we_r ? DONE : RSP;
        end else if (tmo_hit_s) begin
          state_s = DONE;
          abort_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          state_s = DONE;
        end else if (tmo_hit_s) begin
          state_s = DONE;
          abort_s = 1'b1;
        end else begin
          state_s = RSP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; stall is forced low while reset is held
  always_comb begin
    mem_valid  = 1'b0;
    core_stall = 1'b0;
    if (!reset) begin
      mem_valid  = 1'b0;
      core_stall = 1'b0;
    end else begin
      mem_valid = (state_r == REQ);
`ifdef DMEM_WBUF_EN
      // Core is released only by the DONE of its own access or by a store the buffer takes
      core_stall = (((state_r == REQ) || (state_r == RSP)) && !buf_txn_r) ||
                   (req_s && !noop_s &&
                    !((state_r == DONE) && !buf_txn_r) &&
                    !((state_r == IDLE) && !wb_valid_r && core_we));
`else
      core_stall = (state_r == REQ) || (state_r == RSP) ||
                   ((state_r == IDLE) && req_s && !noop_s);
`endif
    end
  end

  // Request latch, timeout counter, read data and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r    <= '0;
      wdata_r   <= 32'h0;
      be_r      <= 4'h0;
      we_r      <= 1'b0;
      tmo_cnt_r <= 16'h0;
      rdata_r   <= 32'h0;
      err_r     <= 1'b0;
    end else begin
      if (start_s) begin
`ifdef DMEM_WBUF_EN
        if (start_buf_s) begin
          addr_r  <= wb_addr_r;
          wdata_r <= wb_wdata_r;
          be_r    <= wb_be_r;
          we_r    <= 1'b1;
        end else begin
          addr_r  <= core_addr[ADDR_W+1:2];
          wdata_r <= core_wdata;
          be_r    <= core_be;
          we_r    <= 1'b0;
        end
`else
        addr_r  <= core_addr[ADDR_W+1:2];
        wdata_r <= core_wdata;
        be_r    <= core_be;
        we_r    <= core_we;
`endif
        tmo_cnt_r <= 16'h0;
      end else if (((state_r == REQ) || (state_r == RSP)) && (tmo_cnt_r != 16'hFFFF)) begin
        tmo_cnt_r <= tmo_cnt_r + 16'h1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end

      if ((state_r == RSP) && mem_rvalid) begin
        rdata_r <= mem_rdata;
      end else if (abort_s) begin
        rdata_r <= 32'h0;
      end else begin
        rdata_r <= rdata_r;
      end

      err_r <= abort_s;
    end
  end

`ifdef DMEM_WBUF_EN
  assign wb_push_s = (state_r == IDLE) && !wb_valid_r && core_we && !noop_s;

  // Posted write buffer and ownership of the access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= '0;
      wb_wdata_r <= 32'h0;
      wb_be_r    <= 4'h0;
      buf_txn_r  <= 1'b0;
    end else begin
      if (wb_push_s) begin
        wb_valid_r <= 1'b1;
        wb_addr_r  <= core_addr[ADDR_W+1:2];
        wb_wdata_r <= core_wdata;
        wb_be_r    <= core_be;
      end else if (start_buf_s) begin
        wb_valid_r <= 1'b0;
      end else begin
        wb_valid_r <= wb_valid_r;
      end

      if (start_s) begin
        buf_txn_r <= start_buf_s;
      end else begin
        buf_txn_r <= buf_txn_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_dmem_ctrl.sv
// Directed self-checking bench for arm_dmem_ctrl (TIMEOUT_CYCLES=8).
module tb_arm_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_be;
  logic        core_we, core_re, core_stall, core_err;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_errors = 0;

  int          st, vc;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_we, held_chg, err;

  arm_dmem_ctrl #(.ADDR_W(30), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_be(core_be),
    .core_we(core_we), .core_re(core_re), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_err(core_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One core access from IDLE; memory responder: ready after rdy_wait valid cycles
  // (-1 = never), rvalid rv_wait cycles after the cycle following the accept.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int rdy_wait, input int rv_wait, input logic [31:0] rdata,
                        output int stalls, output int vcyc,
                        output logic [31:0] ba, output logic [31:0] bw,
                        output logic [3:0] bb, output logic bwe,
                        output logic chg, output logic e);
    int   since;
    logic acc;
    logic done;
    stalls = 0; vcyc = 0; since = 0; acc = 1'b0; done = 1'b0;
    ba = 32'h0; bw = 32'h0; bb = 4'h0; bwe = 1'b0; chg = 1'b0; e = 1'b0;
    core_we = we; core_re = re; core_addr = addr; core_wdata = wdata; core_be = be;
    mem_rdata = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      if (acc) since++;
      mem_rvalid = (acc && (rv_wait >= 0) && (since == rv_wait + 1));
      if (mem_valid) begin
        if (vcyc == 0) begin
          ba = 32'(mem_addr); bw = mem_wdata; bb = mem_be; bwe = mem_we;
        end else if (32'(mem_addr) !== ba || mem_wdata !== bw || mem_be !== bb || mem_we !== bwe) begin
          chg = 1'b1;
        end
        mem_ready = (vcyc == rdy_wait);
        if (mem_ready) begin
          acc = 1'b1; since = 0;
        end
        vcyc++;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      if (core_stall) stalls++;
      else begin
        done = 1'b1; e = core_err;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    check("access_completes", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    core_we = 1'b0; core_re = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_be = 4'h0;
    core_we = 1'b0; core_re = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_stall", {31'h0, core_stall}, 32'h0);
    check("rst_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_err", {31'h0, core_err}, 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    core_re = 1'b0;
    #10 reset = 1'b1;
    @(posedge clk); #1;

`ifndef DMEM_WBUF_EN
    // Write, zero-wait memory
    access(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 4'hF, 0, -1, 32'h0,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("wr_stall", st, 32'd2);
    check("wr_addr", b_addr, 32'h40);
    check("wr_we", {31'h0, b_we}, 32'h1);
    check("wr_wdata", b_wdata, 32'hCAFEF00D);
    check("wr_be", {28'h0, b_be}, 32'hF);
    check("wr_err", {31'h0, err}, 32'h0);
`endif

    // Read: ready on third valid cycle, rvalid the cycle after accept
    access(1'b0, 1'b1, 32'h104, 32'h0, 4'hF, 2, 0, 32'h12345678,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("rd_stall", st, 32'd5);
    check("rd_addr", b_addr, 32'h41);
    check("rd_we", {31'h0, b_we}, 32'h0);
    check("rd_data", core_rdata, 32'h12345678);

    // Reset in RSP, then a stray rvalid
    core_re = 1'b1; core_addr = 32'h108; core_be = 4'hF;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    check("r5_valid", {31'h0, mem_valid}, 32'h1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("r5_rsp_stall", {31'h0, core_stall}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("r5_stall_now", {31'h0, core_stall}, 32'h0);
    check("r5_valid_now", {31'h0, mem_valid}, 32'h0);
    check("r5_rdata_clr", core_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; core_re = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("r5_rvalid_ign", core_rdata, 32'h0);
    check("r5_idle_stall", {31'h0, core_stall}, 32'h0);

`ifndef DMEM_WBUF_EN
    // Byte store held until accepted, then a be==0 no-op store
    access(1'b1, 1'b0, 32'h203, 32'h00AB0000, 4'b0100, 3, -1, 32'h0,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("bs_be", {28'h0, b_be}, 32'h4);
    check("bs_addr", b_addr, 32'h80);
    check("bs_held", {31'h0, held_chg}, 32'h0);
    check("bs_vcyc", vc, 32'd4);
    check("bs_stall", st, 32'd5);
    access(1'b1, 1'b0, 32'h204, 32'h1, 4'h0, 0, -1, 32'h0,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("noop_stall", st, 32'd0);
    check("noop_valid", vc, 32'd0);
`endif

    // Read with slow rvalid
    access(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 0, 2, 32'h0BADF00D,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("rd2_stall", st, 32'd5);
    check("rd2_data", core_rdata, 32'h0BADF00D);

    // Timeout: ready never comes
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, -1, -1, 32'h0,
           st, vc, b_addr, b_wdata, b_be, b_we, held_chg, err);
    check("to_vcyc", vc, 32'd8);
    check("to_stall", st, 32'd9);
    check("to_err", {31'h0, err}, 32'h1);
    check("to_rdata", core_rdata, 32'h0);
    check("to_err_pulse", {31'h0, core_err}, 32'h0);
    check("to_idle", {31'h0, mem_valid}, 32'h0);

`ifdef DMEM_WBUF_EN
    begin
      int          nacc, since, stalls;
      logic        rd_acc, done;
      logic        ord_we [2];
      logic [31:0] ord_addr [2];
      nacc = 0; since = 0; stalls = 0; rd_acc = 1'b0; done = 1'b0;
      ord_we[0] = 1'b0; ord_we[1] = 1'b1; ord_addr[0] = 32'h0; ord_addr[1] = 32'h0;
      core_we = 1'b1; core_addr = 32'h300; core_wdata = 32'hA5A5A5A5; core_be = 4'hF;
      @(negedge clk);
      check("wb_store_stall", {31'h0, core_stall}, 32'h0);
      @(posedge clk); #1;
      core_we = 1'b0; core_re = 1'b1; core_addr = 32'h304; mem_rdata = 32'h5A5A0001;
      for (int c = 0; c < 30 && !done; c++) begin
        if (rd_acc) since++;
        mem_rvalid = rd_acc && (since == 1);
        if (mem_valid) begin
          mem_ready = 1'b1;
          if (nacc < 2) begin
            ord_we[nacc] = mem_we; ord_addr[nacc] = 32'(mem_addr);
          end
          if (!mem_we) begin
            rd_acc = 1'b1; since = 0;
          end
          nacc++;
        end else begin
          mem_ready = 1'b0;
        end
        @(negedge clk);
        if (core_stall) stalls++;
        else done = 1'b1;
        @(posedge clk); #1;
      end
      core_re = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      check("wb_done", {31'h0, done}, 32'h1);
      check("wb_nacc", nacc, 32'd2);
      check("wb_first_we", {31'h0, ord_we[0]}, 32'h1);
      check("wb_first_addr", ord_addr[0], 32'hC0);
      check("wb_second_we", {31'h0, ord_we[1]}, 32'h0);
      check("wb_second_addr", ord_addr[1], 32'hC1);
      check("wb_load_stalled", {31'h0, (stalls > 0)}, 32'h1);
      check("wb_rdata", core_rdata, 32'h5A5A0001);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
